// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM backing-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    RESP
  } arbState_t;

  // Command presented to the backing memory; widths follow the package defaults.
  typedef struct packed {
    logic                        we;
    logic [DEF_ADDR_W-1:0]       addr;
    logic [DEF_DATA_W-1:0]       wdata;
    logic [DEF_DATA_W/8-1:0]     be;
  } memCmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store beats fetch, one req/ack transaction at a time,
// with per-stage stalls and dropping of fetches killed by a taken branch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  arbState_t             state;
  memCmd_t               cmdReg;
  logic                  memReq;
  logic                  respFetch;
  logic                  dropFetch;
  logic                  errReg;
  logic [DATA_W-1:0]     ifData;
  logic [DATA_W-1:0]     dmData;

  // Requests are only sampled in IDLE, so a req still high during RESP cannot be re-accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmdReg    <= '0;
      memReq    <= 1'b0;
      respFetch <= 1'b0;
      dropFetch <= 1'b0;
      errReg    <= 1'b0;
      ifData    <= '0;
      dmData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ack) errReg <= 1'b1;
          if (dm_req) begin
            cmdReg <= '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
            memReq <= 1'b1;
            state  <= BUSY_D;
          end else if (if_req && !if_kill) begin
            cmdReg <= '{we: 1'b0, addr: if_addr, wdata: '0, be: '0};
            memReq <= 1'b1;
            state  <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            dmData    <= mem_rdata;
            memReq    <= 1'b0;
            respFetch <= 1'b0;
            state     <= RESP;
          end
        end
        BUSY_I: begin
          // A killed fetch still completes on memory; only its response is discarded.
          if (if_kill) dropFetch <= 1'b1;
          if (mem_ack) begin
            ifData    <= mem_rdata;
            memReq    <= 1'b0;
            respFetch <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (mem_ack) errReg <= 1'b1;
          dropFetch <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = memReq;
  assign mem_we    = cmdReg.we;
  assign mem_addr  = cmdReg.addr;
  assign mem_wdata = cmdReg.wdata;
  assign mem_be    = cmdReg.be;

  assign if_rdata  = ifData;
  assign dm_rdata  = dmData;
  assign err       = errReg;

  // A kill arriving during the fetch's own RESP cycle must still suppress its pulse.
  assign if_valid  = (state == RESP) && respFetch && !dropFetch && !if_kill;
  assign dm_valid  = (state == RESP) && !respFetch;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule
